// File: rtl/napot_region_programmer_if.sv
// Request / CSR-write / response bundle for the NAPOT region programmer.
// The slave modport is the programmer itself. The master modport is the
// requester side, which also acknowledges CSR writes and takes responses.
interface napot_region_programmer_if #(
  parameter int IDX_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_base;
  logic [5:0]        req_log2size;
  logic [IDX_W-1:0]  req_idx;
  logic [2:0]        req_perm;
  logic              req_lock;

  logic              csr_we;
  logic [11:0]       csr_addr;
  logic [31:0]       csr_wdata;
  logic [3:0]        csr_wstrb;
  logic              csr_ack;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_err;
  logic [31:0]       rsp_pmpaddr;

  modport slave (
    input  req_valid, req_base, req_log2size, req_idx, req_perm, req_lock,
    output req_ready,
    output csr_we, csr_addr, csr_wdata, csr_wstrb,
    input  csr_ack,
    output rsp_valid, rsp_err, rsp_pmpaddr,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_base, req_log2size, req_idx, req_perm, req_lock,
    input  req_ready,
    input  csr_we, csr_addr, csr_wdata, csr_wstrb,
    output csr_ack,
    input  rsp_valid, rsp_err, rsp_pmpaddr,
    output rsp_ready
  );
endinterface

// File: rtl/napot_region_programmer.sv
// NAPOT region programmer: validates a (base, log2 size) request, grows the
// trailing-ones mask one bit per cycle, writes pmpaddrN and its pmpcfg byte
// through the CSR write port, then returns the encoded pmpaddr.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request; captures req_* and clears the mask
// CHECK   | one cycle of size/alignment/index validation
// BUILD   | shifts one trailing-ones bit into the mask per cycle
// WR_ADDR | pmpaddrN write held on the CSR port until acked
// WR_CFG  | pmpcfg byte-lane write held on the CSR port until acked
// RESP    | response held until consumed
module napot_region_programmer #(
  parameter int XLEN    = 32,
  parameter int NUM_PMP = 16,
  parameter int IDX_W   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  napot_region_programmer_if.slave       bus
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    BUILD,
    WR_ADDR,
    WR_CFG,
    RESP
  } state_t;

  state_t            state_q, state_d;

  // captured request
  logic [XLEN-1:0]   base_q, base_d;
  logic [5:0]        n_q, n_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [2:0]        perm_q, perm_d;
  logic              lock_q, lock_d;

  // encode datapath
  logic [XLEN-1:0]   mask_q, mask_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  // registered outputs
  logic              req_ready_q, req_ready_d;
  logic              csr_we_q, csr_we_d;
  logic [11:0]       csr_addr_q, csr_addr_d;
  logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
  logic [3:0]        csr_wstrb_q, csr_wstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [XLEN-1:0]   rsp_pmpaddr_q, rsp_pmpaddr_d;

  // validation helpers
  logic [XLEN-1:0]   align_mask;
  logic              bad_req;

  // output staging helpers
  logic [XLEN-1:0]   pmpaddr_d;
  logic [7:0]        cfg_byte;
  logic [1:0]        byte_sel;

  // Low bits of base that must be zero for a naturally aligned region;
  // a region of 4 GiB or more only fits at base 0.
  always_comb begin
    align_mask = '0;
    if (n_q >= 6'd32) begin
      align_mask = '1;
    end else begin
      align_mask = (XLEN'(1) << n_q[4:0]) - XLEN'(1);
    end
    bad_req = (n_q < 6'd3) || (n_q > 6'd34) ||
              ((base_q & align_mask) != '0) ||
              !(int'(idx_q) < NUM_PMP);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    n_d     = n_q;
    idx_d   = idx_q;
    perm_d  = perm_q;
    lock_d  = lock_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          base_d  = bus.req_base;
          n_d     = bus.req_log2size;
          idx_d   = bus.req_idx;
          perm_d  = bus.req_perm;
          lock_d  = bus.req_lock;
          mask_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (bad_req) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (n_q == 6'd3) begin
          state_d = WR_ADDR;
        end else begin
          cnt_d   = 5'(n_q - 6'd3);
          state_d = BUILD;
        end
      end
      BUILD: begin
        mask_d = {mask_q[XLEN-2:0], 1'b1};
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = WR_ADDR;
        end
      end
      WR_ADDR: begin
        if (csr_we_q && bus.csr_ack) begin
          state_d = WR_CFG;
        end
      end
      WR_CFG: begin
        if (csr_we_q && bus.csr_ack) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the coming state, so every output leaves a flop.
  always_comb begin
    pmpaddr_d     = (base_d >> 2) | mask_d;
    cfg_byte      = {lock_d, 2'b00, 2'b11, perm_d};
    byte_sel      = idx_d[1:0];

    req_ready_d   = (state_d == IDLE);
    csr_we_d      = 1'b0;
    csr_addr_d    = '0;
    csr_wdata_d   = '0;
    csr_wstrb_d   = '0;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_pmpaddr_d = '0;

    case (state_d)
      WR_ADDR: begin
        csr_we_d    = 1'b1;
        csr_addr_d  = 12'h3B0 + 12'(idx_d);
        csr_wdata_d = pmpaddr_d;
        csr_wstrb_d = 4'hF;
      end
      WR_CFG: begin
        csr_we_d    = 1'b1;
        csr_addr_d  = 12'h3A0 + 12'(idx_d[IDX_W-1:2]);
        csr_wdata_d = XLEN'(cfg_byte) << {byte_sel, 3'b000};
        csr_wstrb_d = 4'b0001 << byte_sel;
      end
      RESP: begin
        rsp_valid_d   = 1'b1;
        rsp_err_d     = err_d;
        rsp_pmpaddr_d = err_d ? '0 : pmpaddr_d;
      end
      default: begin
      end
    endcase
  end

  // State, captured request and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      n_q           <= '0;
      idx_q         <= '0;
      perm_q        <= '0;
      lock_q        <= 1'b0;
      mask_q        <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      req_ready_q   <= 1'b1;
      csr_we_q      <= 1'b0;
      csr_addr_q    <= '0;
      csr_wdata_q   <= '0;
      csr_wstrb_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_pmpaddr_q <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      n_q           <= n_d;
      idx_q         <= idx_d;
      perm_q        <= perm_d;
      lock_q        <= lock_d;
      mask_q        <= mask_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      req_ready_q   <= req_ready_d;
      csr_we_q      <= csr_we_d;
      csr_addr_q    <= csr_addr_d;
      csr_wdata_q   <= csr_wdata_d;
      csr_wstrb_q   <= csr_wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_pmpaddr_q <= rsp_pmpaddr_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.csr_we      = csr_we_q;
  assign bus.csr_addr    = csr_addr_q;
  assign bus.csr_wdata   = csr_wdata_q;
  assign bus.csr_wstrb   = csr_wstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_pmpaddr = rsp_pmpaddr_q;

endmodule

// File: tb/tb_napot_region_programmer.sv
// Bench for napot_region_programmer: expected CSR writes and responses are
// queued when a request is driven and popped as the DUT produces them.
module tb_napot_region_programmer;

  logic clk;
  logic rst;

  napot_region_programmer_if #(.IDX_W(4)) bus ();

  napot_region_programmer #(
    .XLEN    (32),
    .NUM_PMP (16),
    .IDX_W   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_rsp;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass;
  int   n_total;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference encoding: alignment via modulo, trailing ones via 2^(n-3)-1.
  function automatic void sb_push(input logic [31:0] base, input int n, input int idx,
                                  input logic [2:0] perm, input logic lock, input int ack_wait);
    exp_t            e;
    bit              legal;
    longint unsigned pa;
    longint unsigned cfg;
    legal = (n >= 3) && (n <= 34) && ((longint'(base) % (64'd1 << n)) == 0);
    if (legal) begin
      pa  = (longint'(base) >> 2) + ((64'd1 << (n - 3)) - 1);
      cfg = longint'({lock, 2'b00, 2'b11, perm});
      e = '{is_rsp: 0, addr: 12'(12'h3B0 + idx), data: pa[31:0], strb: 4'hF, err: 0, lat: 0};
      sb.push_back(e);
      cfg = cfg << (8 * (idx % 4));
      e = '{is_rsp: 0, addr: 12'(12'h3A0 + idx / 4), data: cfg[31:0],
            strb: 4'(1 << (idx % 4)), err: 0, lat: 0};
      sb.push_back(e);
      e = '{is_rsp: 1, addr: 0, data: pa[31:0], strb: 0, err: 0, lat: n + 1 + ack_wait};
      sb.push_back(e);
    end else begin
      e = '{is_rsp: 1, addr: 0, data: 32'h0, strb: 0, err: 1, lat: 2};
      sb.push_back(e);
    end
  endfunction

  task automatic drive_req(input logic [31:0] base, input int n, input int idx,
                           input logic [2:0] perm, input logic lock);
    int k;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_base     = base;
    bus.req_log2size = 6'(n);
    bus.req_idx      = 4'(idx);
    bus.req_perm     = perm;
    bus.req_lock     = lock;
    bus.req_valid    = 1'b1;
    @(negedge clk);
    bus.req_valid    = 1'b0;
  endtask

  task automatic run_req(input logic [31:0] base, input int n, input int idx,
                         input logic [2:0] perm, input logic lock,
                         input int ack_wait, input int rsp_wait, input bit pulse);
    exp_t        e;
    exp_t        r;
    int          cyc;
    int          wl;
    int          rl;
    int          nwr;
    bit          in_wr;
    bit          rsp_seen;
    bit          done;
    logic [11:0] s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_strb;
    sb_push(base, n, idx, perm, lock, ack_wait);
    drive_req(base, n, idx, perm, lock);
    cyc = 1; wl = 0; rl = 0; nwr = 0;
    in_wr = 0; rsp_seen = 0; done = 0;
    s_addr = '0; s_data = '0; s_strb = '0;
    r = '{is_rsp: 1, addr: 0, data: 0, strb: 0, err: 0, lat: 0};
    for (int t = 0; t < 400 && !done; t++) begin
      bus.req_valid = 1'b0;
      if (bus.csr_we) begin
        if (!in_wr) begin
          if (sb.size() == 0 || sb[0].is_rsp) begin
            chk("unexpected_csr_we", 32'd1, 32'd0);
            wl = 0;
          end else begin
            e = sb.pop_front();
            chk("csr_addr", 32'(bus.csr_addr), 32'(e.addr));
            chk("csr_wdata", bus.csr_wdata, e.data);
            chk("csr_wstrb", 32'(bus.csr_wstrb), 32'(e.strb));
            wl = (nwr == 0) ? ack_wait : 0;
          end
          in_wr = 1;
          nwr++;
          s_addr = bus.csr_addr; s_data = bus.csr_wdata; s_strb = bus.csr_wstrb;
        end else begin
          chk("csr_hold_addr", 32'(bus.csr_addr), 32'(s_addr));
          chk("csr_hold_wdata", bus.csr_wdata, s_data);
          chk("csr_hold_wstrb", 32'(bus.csr_wstrb), 32'(s_strb));
          chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
        end
        if (wl == 0) begin
          bus.csr_ack = 1'b1;
          in_wr = 0;
        end else begin
          bus.csr_ack = 1'b0;
          wl--;
          if (pulse && wl == 2) bus.req_valid = 1'b1;
        end
      end else begin
        bus.csr_ack = 1'b0;
        in_wr = 0;
      end

      if (bus.rsp_valid) begin
        if (!rsp_seen) begin
          if (sb.size() == 0 || !sb[0].is_rsp) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            r = sb.pop_front();
          end
          chk("rsp_err", 32'(bus.rsp_err), 32'(r.err));
          chk("rsp_pmpaddr", bus.rsp_pmpaddr, r.data);
          chk("rsp_latency", 32'(cyc), 32'(r.lat));
          rsp_seen = 1;
          rl = rsp_wait;
        end else begin
          chk("rsp_hold_pmpaddr", bus.rsp_pmpaddr, r.data);
          chk("rsp_hold_err", 32'(bus.rsp_err), 32'(r.err));
          chk("req_ready_in_rsp", 32'(bus.req_ready), 32'd0);
        end
        if (rl == 0) begin
          bus.rsp_ready = 1'b1;
        end else begin
          bus.rsp_ready = 1'b0;
          rl--;
          if (pulse && rl == 1) bus.req_valid = 1'b1;
        end
      end else if (rsp_seen) begin
        chk("req_ready_after_rsp", 32'(bus.req_ready), 32'd1);
        chk("csr_we_after_rsp", 32'(bus.csr_we), 32'd0);
        bus.rsp_ready = 1'b0;
        done = 1;
      end

      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    bus.csr_ack   = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_csr_we"}, 32'(bus.csr_we), 32'd0);
    chk({tag, "_csr_addr"}, 32'(bus.csr_addr), 32'd0);
    chk({tag, "_csr_wdata"}, bus.csr_wdata, 32'd0);
    chk({tag, "_csr_wstrb"}, 32'(bus.csr_wstrb), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, "_rsp_pmpaddr"}, bus.rsp_pmpaddr, 32'd0);
  endtask

  initial begin
    int          rn;
    logic [31:0] rbase;
    n_pass  = 0;
    n_total = 0;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_base     = '0;
    bus.req_log2size = '0;
    bus.req_idx      = '0;
    bus.req_perm     = '0;
    bus.req_lock     = 1'b0;
    bus.csr_ack      = 1'b0;
    bus.rsp_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // directed encodes
    run_req(32'h8000_0000, 12, 5, 3'b011, 1'b0, 0, 0, 0);
    run_req(32'h0000_1000, 3, 0, 3'b111, 1'b1, 0, 0, 0);
    run_req(32'h0000_0000, 34, 15, 3'b101, 1'b1, 0, 0, 0);

    // illegal requests
    run_req(32'h8000_0800, 12, 2, 3'b001, 1'b0, 0, 0, 0);
    run_req(32'h0000_0000, 2, 1, 3'b001, 1'b0, 0, 0, 0);
    run_req(32'h0000_0000, 35, 1, 3'b001, 1'b0, 0, 0, 0);
    run_req(32'h0000_0004, 32, 3, 3'b001, 1'b0, 0, 0, 0);

    // CSR and response back-pressure with a stray request pulse
    run_req(32'h8000_0000, 12, 5, 3'b011, 1'b0, 5, 3, 1);

    // reset in the middle of BUILD, then a normal request
    sb_push(32'h8000_0000, 12, 5, 3'b011, 1'b0, 0);
    drive_req(32'h8000_0000, 12, 5, 3'b011, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    run_req(32'h8000_0000, 12, 5, 3'b011, 1'b0, 0, 0, 0);

    // random legal requests
    for (int i = 0; i < 6; i++) begin
      rn    = int'($urandom_range(3, 34));
      rbase = (rn >= 32) ? 32'h0 : (($urandom() >> rn) << rn);
      run_req(rbase, rn, int'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 0, int'($urandom_range(0, 2)), 0);
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
